// File: rtl/egress_drain.sv
// Round-robin drain of four egress FIFOs into one held output word.
// Each word costs four cycles: decide, pop, capture, send.
module egress_drain #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [3:0]            empty,
  input  logic [DATA_WIDTH-1:0] data_in4,
  input  logic [DATA_WIDTH-1:0] data_in5,
  input  logic [DATA_WIDTH-1:0] data_in6,
  input  logic [DATA_WIDTH-1:0] data_in7,
  input  logic                  ready,
  input  logic [1:0]            idx,
  output logic [3:0]            pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            channel_out,
  output logic [CNT_WIDTH-1:0]  count_out
);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    CAPT,
    SEND
  } state_t;

  state_t state, state_nx;

  logic [1:0]            grant;
  logic [1:0]            last_grant;
  logic [1:0]            pick;
  logic [1:0]            cand;
  logic                  found;
  logic                  start;
  logic                  done;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CNT_WIDTH-1:0]  cnt [4];

  // search starts just past the last served channel
  always_comb begin
    pick  = last_grant;
    found = 1'b0;
    cand  = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!found && !empty[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign start = (state == IDLE) && enable && found;
  assign done  = (state == SEND) && ready;

  always_comb begin
    sel_data = data_in4;
    unique case (grant)
      2'd0: sel_data = data_in4;
      2'd1: sel_data = data_in5;
      2'd2: sel_data = data_in6;
      2'd3: sel_data = data_in7;
      default: sel_data = data_in4;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = POP;
      POP:     state_nx = CAPT;
      CAPT:    state_nx = SEND;
      SEND:    if (ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop         <= 4'b0000;
      grant       <= 2'd0;
      last_grant  <= 2'd3;
      data_out    <= '0;
      valid_out   <= 1'b0;
      channel_out <= 2'd0;
    end else begin
      pop <= start ? (4'b0001 << pick) : 4'b0000;
      if (start) grant <= pick;
      if (state == CAPT) begin
        data_out    <= sel_data;
        channel_out <= grant;
        valid_out   <= 1'b1;
        last_grant  <= grant;
      end
      if (done) valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else if (done) begin
      cnt[grant] <= cnt[grant] + CNT_WIDTH'(1);
    end
  end

  assign count_out = cnt[idx];

endmodule

// File: tb/tb_egress_drain.sv
// Scoreboard bench for egress_drain: directed stimulus pushes expected
// words, a negedge monitor pops them on each valid/ready handshake.
module tb_egress_drain;

  localparam int DW = 12;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [3:0]    empty;
  logic [DW-1:0] d4, d5, d6, d7;
  logic          ready;
  logic [1:0]    idx;
  logic [3:0]    pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [1:0]    channel_out;
  logic [CW-1:0] count_out;

  egress_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .empty(empty),
    .data_in4(d4), .data_in5(d5), .data_in6(d6), .data_in7(d7),
    .ready(ready), .idx(idx), .pop(pop), .data_out(data_out),
    .valid_out(valid_out), .channel_out(channel_out),
    .count_out(count_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    ch;
    logic [DW-1:0] d;
  } exp_t;

  exp_t   q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint prev;
  bit     ok;
  int     exp_cnt [4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset && valid_out && ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got ch %0d data %h, expected none",
                 channel_out, data_out);
      end else begin
        mon_e = q.pop_front();
        if (channel_out !== mon_e.ch || data_out !== mon_e.d) begin
          errors++;
          $display("FAIL word: got ch %0d data %h, expected ch %0d data %h",
                   channel_out, data_out, mon_e.ch, mon_e.d);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] ch);
    exp_t e;
    e.ch = ch;
    e.d  = 12'h404 + DW'(ch);
    q.push_back(e);
  endtask

  task automatic wait_pop(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pop != 4'b0000) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got no pop, expected pop within 12 cycles");
    end
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_out) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got no valid, expected valid in 12 cycles");
    end
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    enable = 1'b0;
    ready  = 1'b0;
    empty  = 4'hF;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_count(input string name, input logic [1:0] ch,
                             input int exp);
    idx = ch;
    #1 check(name, 32'(count_out), 32'(exp));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; ready = 1'b0; empty = 4'hF; idx = 2'd0;
    d4 = 12'h404; d5 = 12'h405; d6 = 12'h406; d7 = 12'h407;

    // reset state
    #2;
    check("rst_pop", 32'(pop), 0);
    check("rst_valid", 32'(valid_out), 0);
    check("rst_data", 32'(data_out), 0);
    check("rst_channel", 32'(channel_out), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // all empty: nothing happens
    enable = 1'b1; ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("empty_pop", 32'(pop), 0);
      check("empty_valid", 32'(valid_out), 0);
    end
    for (int i = 0; i < 4; i++) check_count("empty_count", 2'(i), 0);

    // all non-empty round robin
    do_reset();
    @(posedge clk);
    #1 empty = 4'b0000; ready = 1'b1; enable = 1'b1;
    for (int n = 0; n < 5; n++) push(2'(n % 4));
    prev = 0;
    for (int n = 0; n < 5; n++) begin
      wait_pop(ok);
      if (!ok) break;
      check("rr_pop", 32'(pop), 32'(4'b0001 << (n % 4)));
      if (n > 0) check("rr_spacing", 32'(cyc - prev), 4);
      prev = cyc;
      if (n == 4) enable = 1'b0;
    end
    repeat (6) @(negedge clk);
    exp_cnt = '{2, 1, 1, 1};
    for (int i = 0; i < 4; i++) check_count("rr_count", 2'(i), exp_cnt[i]);
    check("rr_hold_data", 32'(data_out), 32'h404);
    check("rr_valid_low", 32'(valid_out), 0);

    // backpressure on channel 2
    do_reset();
    @(posedge clk);
    #1 empty = 4'b1011; ready = 1'b0; enable = 1'b1;
    push(2'd2);
    wait_valid(ok);
    for (int i = 0; i < 6; i++) begin
      check("stall_valid", 32'(valid_out), 1);
      check("stall_data", 32'(data_out), 32'h406);
      check("stall_channel", 32'(channel_out), 2);
      check("stall_pop", 32'(pop), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 ready = 1'b1; enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("stall_drop", 32'(valid_out), 0);
    check_count("stall_count", 2'd2, 1);

    // enable dropped while pop is high
    do_reset();
    @(posedge clk);
    #1 empty = 4'b0000; ready = 1'b1; enable = 1'b1;
    push(2'd0);
    @(posedge clk);
    #1 check("en_pop", 32'(pop), 32'h1);
    enable = 1'b0;
    @(negedge clk);
    repeat (10) begin
      @(negedge clk);
      check("en_nopop", 32'(pop), 0);
    end
    check_count("en_count", 2'd0, 1);

    // reset during send
    do_reset();
    @(posedge clk);
    #1 empty = 4'b0000; ready = 1'b0; enable = 1'b1;
    wait_valid(ok);
    #1 reset = 1'b0;
    #1 check("rsend_valid", 32'(valid_out), 0);
    check("rsend_pop", 32'(pop), 0);
    check("rsend_data", 32'(data_out), 0);
    check_count("rsend_count", 2'd0, 0);
    @(posedge clk);
    #1 reset = 1'b1; ready = 1'b1;
    push(2'd0);
    wait_pop(ok);
    check("rsend_grant", 32'(pop), 32'h1);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    check_count("rsend_count2", 2'd0, 1);

    // counter wrap on channel 1
    do_reset();
    @(posedge clk);
    #1 empty = 4'b1101; ready = 1'b1; enable = 1'b1;
    repeat (33) push(2'd1);
    for (int n = 0; n < 33; n++) begin
      wait_pop(ok);
      if (!ok) break;
      check("wrap_pop", 32'(pop), 32'h2);
      if (n == 32) begin
        enable = 1'b0;
        check_count("wrap_at_32", 2'd1, 0);
      end
    end
    repeat (6) @(negedge clk);
    check_count("wrap_count", 2'd1, 1);

    check("scoreboard_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
